// File: rtl/comb_pkg.sv
// comb_pkg
//   Shared types and constants for the packed operand path.
//   - DW_DEF      : default half-word width (32).
//   - cs_state_t  : splitter FSM states {IDLE, HI, LO}.
//   - comb_word_t : packed {op1, op2} word as produced by the packing stage.
package comb_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } cs_state_t;

  typedef logic [2*DW_DEF-1:0] comb_word_t;

endpackage

// File: rtl/comb_sum_check.sv
// comb_sum_check
//   Purely combinational cross-check of the adder output. The two halves are
//   added at full DW+1 width, so the carry out is kept, and the result is
//   compared against the sum that travelled with the word.
// Ports:
//   hi, lo    in  DW    operands (op1, op2)
//   exp_sum   in  DW+1  sum supplied by the upstream adder
//   mismatch  out 1     high when exp_sum differs from hi + lo
module comb_sum_check #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  input  logic [DW:0]   exp_sum,
  output logic          mismatch
);

  logic [DW:0] sum;

  assign sum      = {1'b0, hi} + {1'b0, lo};
  assign mismatch = (sum != exp_sum);

endmodule

// File: rtl/comb_splitter.sv
// comb_splitter
//   Width down-converter: accepts one packed {op1, op2} word plus its
//   precomputed sum and replays op1 then op2 as two DW-bit half-words.
//   The sum is checked on accept; mismatches pulse sum_err and bump a
//   saturating counter, but both halves are always forwarded.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   in_valid/in_ready packed word handshake (in_ready never depends on in_valid)
//   in_data  [2*DW]   {op1, op2}, op1 in the upper half
//   in_sum   [DW+1]   expected op1 + op2
//   out_valid/out_ready half-word handshake
//   out_data [DW]     current half-word
//   out_last          high on the op2 half
//   sum_err           one-cycle pulse, aligned with the first HI cycle
//   err_cnt  [CNT_W]  saturating mismatch count
module comb_splitter
  import comb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_data,
  input  logic [DW:0]     in_sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            sum_err,
  output logic [CNT_W-1:0] err_cnt
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  cs_state_t        state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             sum_err_q, sum_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [DW-1:0]    lo_q, lo_d;

  logic accept;
  logic mismatch;

  comb_sum_check #(
    .DW (DW)
  ) u_sum_check (
    .hi       (in_data[2*DW-1:DW]),
    .lo       (in_data[DW-1:0]),
    .exp_sum  (in_sum),
    .mismatch (mismatch)
  );

  // Ready from state and out_ready only; LO can hand over to the next word
  // in the same cycle its second half is consumed.
  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == LO) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    lo_d        = lo_q;
    sum_err_d   = accept && mismatch;
    err_cnt_d   = (accept && mismatch) ? sat_inc(err_cnt_q) : err_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = HI;
          out_valid_d = 1'b1;
          out_data_d  = in_data[2*DW-1:DW];
          out_last_d  = 1'b0;
          lo_d        = in_data[DW-1:0];
        end
      end
      HI: begin
        if (out_ready) begin
          state_d    = LO;
          out_data_d = lo_q;
          out_last_d = 1'b1;
        end
      end
      LO: begin
        if (out_ready) begin
          if (accept) begin
            state_d     = HI;
            out_valid_d = 1'b1;
            out_data_d  = in_data[2*DW-1:DW];
            out_last_d  = 1'b0;
            lo_d        = in_data[DW-1:0];
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sum_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sum_err_q   <= sum_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Pending op2 half; only meaningful while in HI, so it needs no reset.
  always_ff @(posedge clk) begin
    lo_q <= lo_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sum_err   = sum_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_comb_splitter.sv
// tb_comb_splitter
//   Directed bench for comb_splitter. Inputs change and outputs are sampled
//   on the falling clock edge, half a cycle away from the active edge.
module tb_comb_splitter;

  localparam int DW    = 32;
  localparam int CNT_W = 8;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] in_data;
  logic [DW:0]     in_sum;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            sum_err;
  logic [CNT_W-1:0] err_cnt;

  int n_checks;
  int n_errors;

  comb_splitter #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sum_err   (sum_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d, input logic l);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".data"},  64'(out_data),  64'(d));
    chk({tag, ".last"},  64'(out_last),  64'(l));
  endtask

  // Single isolated word from IDLE with out_ready held high.
  task automatic run_word(input string tag, input logic [2*DW-1:0] d, input logic [DW:0] s,
                          input logic exp_err, input logic [CNT_W-1:0] exp_cnt);
    in_valid  = 1'b1;
    in_data   = d;
    in_sum    = s;
    out_ready = 1'b1;
    #1 chk({tag, ".rdy_idle"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out({tag, ".hi"}, 1'b1, d[2*DW-1:DW], 1'b0);
    chk({tag, ".sum_err_hi"}, 64'(sum_err), 64'(exp_err));
    chk({tag, ".cnt"}, 64'(err_cnt), 64'(exp_cnt));
    #1 chk({tag, ".rdy_hi"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    chk_out({tag, ".lo"}, 1'b1, d[DW-1:0], 1'b1);
    chk({tag, ".sum_err_lo"}, 64'(sum_err), 64'd0);
    @(negedge clk);
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  logic [2*DW-1:0] b2b_data [3];
  logic [DW:0]     b2b_sum  [3];
  logic [CNT_W-1:0] exp_cnt;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sum    = '0;
    out_ready = 1'b0;

    b2b_data[0] = 64'h11111111_22222222; b2b_sum[0] = 33'h0_33333333;
    b2b_data[1] = 64'hA5A5A5A5_5A5A5A5A; b2b_sum[1] = 33'h0_FFFFFFFF;
    b2b_data[2] = 64'h80000000_80000000; b2b_sum[2] = 33'h1_00000000;

    // Reset state
    repeat (3) @(negedge clk);
    chk_out("reset", 1'b0, 32'h0, 1'b0);
    chk("reset.sum_err", 64'(sum_err), 64'd0);
    chk("reset.err_cnt", 64'(err_cnt), 64'd0);
    out_ready = 1'b1;
    #1 chk("reset.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Single word and carry boundary
    run_word("single", 64'h00000005_00000003, 33'h0_00000008, 1'b0, 8'd0);
    run_word("carry_ok", 64'hFFFFFFFF_00000001, 33'h1_00000000, 1'b0, 8'd0);
    run_word("carry_bad", 64'hFFFFFFFF_00000001, 33'h0_00000000, 1'b1, 8'd1);

    // Back-to-back: in_valid held, six half-words with no gap
    in_valid  = 1'b1;
    in_data   = b2b_data[0];
    in_sum    = b2b_sum[0];
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        in_data = b2b_data[i+1];
        in_sum  = b2b_sum[i+1];
      end else begin
        in_valid = 1'b0;
      end
      chk_out($sformatf("b2b%0d.hi", i), 1'b1, b2b_data[i][2*DW-1:DW], 1'b0);
      #1 chk($sformatf("b2b%0d.rdy_hi", i), 64'(in_ready), 64'd0);
      @(negedge clk);
      chk_out($sformatf("b2b%0d.lo", i), 1'b1, b2b_data[i][DW-1:0], 1'b1);
      chk($sformatf("b2b%0d.rdy_lo", i), 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    chk("b2b.idle_valid", 64'(out_valid), 64'd0);
    chk("b2b.idle_rdy", 64'(in_ready), 64'd1);
    chk("b2b.err_cnt", 64'(err_cnt), 64'd1);

    // Backpressure: five stalled HI cycles
    in_valid  = 1'b1;
    in_data   = 64'hDEADBEEF_CAFEF00D;
    in_sum    = 33'h1_A9ACAEFC;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("bp_stall%0d", k), 1'b1, 32'hDEADBEEF, 1'b0);
      chk($sformatf("bp_stall%0d.rdy", k), 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_release.rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk_out("bp.lo", 1'b1, 32'hCAFEF00D, 1'b1);
    @(negedge clk);
    chk("bp.idle_valid", 64'(out_valid), 64'd0);
    chk("bp.err_cnt", 64'(err_cnt), 64'd1);

    // Saturation: 300 mismatching words streamed back-to-back
    exp_cnt  = 8'd1;
    in_valid = 1'b1;
    in_data  = {32'd0, 32'h10};
    in_sum   = 33'h11;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      chk($sformatf("sat%0d.sum_err", i), 64'(sum_err), 64'd1);
      chk($sformatf("sat%0d.cnt", i), 64'(err_cnt), 64'(exp_cnt));
      chk($sformatf("sat%0d.hi", i), 64'(out_data), 64'(i));
      if (i < 299) begin
        in_data = {32'(i + 1), 32'h10};
        in_sum  = 33'(i + 1) + 33'h11;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("sat%0d.sum_err_lo", i), 64'(sum_err), 64'd0);
      @(negedge clk);
    end
    chk("sat.final_cnt", 64'(err_cnt), 64'd255);

    // Reset during LO
    in_valid  = 1'b1;
    in_data   = 64'h01234567_89ABCDEF;
    in_sum    = 33'h0_8ACF1356;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("rst_mid.hi", 1'b1, 32'h01234567, 1'b0);
    @(negedge clk);
    chk_out("rst_mid.lo", 1'b1, 32'h89ABCDEF, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid.valid", 64'(out_valid), 64'd0);
    chk("rst_mid.err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_mid.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel.valid", 64'(out_valid), 64'd0);
    run_word("after_rst", 64'h00000007_00000009, 33'h0_00000010, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
